// File: rtl/audio_port_pkg.sv
// rtl/audio_port_pkg.sv - register map constants and status word packing for the audio sample port
package audio_port_pkg;

   localparam logic ADDR_DATA   = 1'b0;
   localparam logic ADDR_STATUS = 1'b1;

   localparam int EMPTY_BIT = 0;
   localparam int FULL_BIT  = 1;
   localparam int OVF_BIT   = 2;
   localparam int COUNT_LSB = 8;

   function automatic logic [31:0] pack_status(input logic empty, input logic full,
                                               input logic ovf, input logic [7:0] count);
      logic [31:0] word;
      word                        = '0;
      word[EMPTY_BIT]             = empty;
      word[FULL_BIT]              = full;
      word[OVF_BIT]               = ovf;
      word[COUNT_LSB +: 8]        = count;
      return word;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through FIFO with occupancy count
module sync_fifo
   import audio_port_pkg::*;
#(
   parameter int WIDTH = 28,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [AW:0]      count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign rdata = mem[rd_ptr];

   // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/driver_audio_sample_port.sv
// rtl/driver_audio_sample_port.sv - audio sample stream into a FIFO read through a DATA/STATUS window
module driver_audio_sample_port
   import audio_port_pkg::*;
#(
   parameter int DATA_SIZE  = 28,
   parameter int FIFO_DEPTH = 16,
   localparam int AW        = $clog2(FIFO_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 chipselect,
   input  logic                 address,
   input  logic                 read,
   input  logic                 source_valid,
   input  logic [DATA_SIZE-1:0] source_data,
   output logic                 source_ready,
   output logic [31:0]          read_data,
   output logic                 irq
);

   logic                 rd_sel;
   logic                 data_rd;
   logic                 status_rd;
   logic [DATA_SIZE-1:0] head;
   logic [AW:0]          count;
   logic                 empty;
   logic                 full;
   logic                 ovf;
   logic                 ovf_set;

   assign source_ready = 1'b1;
   assign irq          = 1'b0;

   assign rd_sel    = chipselect && read;
   assign data_rd   = rd_sel && (address == ADDR_DATA);
   assign status_rd = rd_sel && (address == ADDR_STATUS);

   sync_fifo #(
      .WIDTH (DATA_SIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (source_valid),
      .pop   (data_rd),
      .wdata (source_data),
      .rdata (head),
      .count (count),
      .empty (empty),
      .full  (full)
   );

   // Drop only when nothing leaves on this edge; a concurrent pop makes room.
   assign ovf_set = source_valid && full && !data_rd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (ovf_set) begin
         ovf <= 1'b1;
      end else if (status_rd) begin
         ovf <= 1'b0;
      end
   end

   always_comb begin
      read_data = '0;
      if (!rst && data_rd && !empty) begin
         read_data = 32'(head);
      end else if (!rst && status_rd) begin
         read_data = pack_status(empty, full, ovf, 8'(count));
      end
   end

endmodule

// File: tb/tb_driver_audio_sample_port.sv
// tb/tb_driver_audio_sample_port.sv - directed self-checking bench for driver_audio_sample_port
module tb_driver_audio_sample_port;

   logic        clk;
   logic        rst;
   logic        chipselect;
   logic        address;
   logic        read;
   logic        source_valid;
   logic [27:0] source_data;
   logic        source_ready;
   logic [31:0] read_data;
   logic        irq;

   int errors = 0;
   int checks = 0;

   driver_audio_sample_port #(
      .DATA_SIZE  (28),
      .FIFO_DEPTH (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .chipselect   (chipselect),
      .address      (address),
      .read         (read),
      .source_valid (source_valid),
      .source_data  (source_data),
      .source_ready (source_ready),
      .read_data    (read_data),
      .irq          (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic check_const(input string tag);
      check({tag, "_ready"}, {31'd0, source_ready}, 32'd1);
      check({tag, "_irq"}, {31'd0, irq}, 32'd0);
   endtask

   task automatic push(input logic [27:0] d);
      @(negedge clk);
      source_valid = 1'b1;
      source_data  = d;
      @(posedge clk);
      #1;
      source_valid = 1'b0;
   endtask

   // Single-cycle read: sampled mid-cycle, strobe held across exactly one posedge.
   task automatic bus_read(input logic a, input logic [31:0] exp, input string tag);
      @(negedge clk);
      chipselect = 1'b1;
      read       = 1'b1;
      address    = a;
      #1;
      check(tag, read_data, exp);
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      read       = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      chipselect   = 1'b0;
      address      = 1'b0;
      read         = 1'b0;
      source_valid = 1'b0;
      source_data  = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chipselect = 1'b1;
      read       = 1'b1;
      address    = 1'b1;
      #1;
      check("reset_rd_status", read_data, 32'h0);
      check_const("reset");
      chipselect = 1'b0;
      read       = 1'b0;
      rst        = 1'b0;

      bus_read(1'b1, 32'h0000_0001, "idle_status");

      push(28'h1234567);
      bus_read(1'b0, 32'h0123_4567, "basic_data");
      bus_read(1'b1, 32'h0000_0001, "basic_status");

      push(28'hABCDEF0);
      push(28'h9876543);
      bus_read(1'b0, 32'h0ABC_DEF0, "order_0");
      bus_read(1'b0, 32'h0987_6543, "order_1");

      push(28'h5555555);
      bus_read(1'b1, 32'h0000_0100, "status_cnt1");
      bus_read(1'b0, 32'h0555_5555, "status_keep");
      bus_read(1'b1, 32'h0000_0001, "status_empty");
      bus_read(1'b0, 32'h0000_0000, "empty_data");

      push(28'h0BBBBBB);
      @(negedge clk);
      rst          = 1'b1;
      source_valid = 1'b1;
      source_data  = 28'hAAAAAAA;
      @(posedge clk);
      #1;
      check_const("in_reset");
      @(negedge clk);
      rst          = 1'b0;
      source_valid = 1'b0;
      bus_read(1'b0, 32'h0000_0000, "rst_mid_data");
      bus_read(1'b1, 32'h0000_0001, "rst_mid_status");

      @(negedge clk);
      source_valid = 1'b1;
      source_data  = 28'h1111111;
      @(negedge clk);
      source_data  = 28'h2222222;
      @(negedge clk);
      source_data  = 28'h3333333;
      @(negedge clk);
      source_valid = 1'b0;
      chipselect   = 1'b1;
      read         = 1'b1;
      address      = 1'b0;
      #1;
      check("b2b_0", read_data, 32'h0111_1111);
      @(negedge clk);
      #1;
      check("b2b_1", read_data, 32'h0222_2222);
      @(negedge clk);
      #1;
      check("b2b_2", read_data, 32'h0333_3333);
      @(negedge clk);
      #1;
      check("b2b_empty", read_data, 32'h0);
      chipselect = 1'b0;
      read       = 1'b0;

      // Push and pop attempt together on an empty FIFO.
      @(negedge clk);
      source_valid = 1'b1;
      source_data  = 28'h7777777;
      chipselect   = 1'b1;
      read         = 1'b1;
      address      = 1'b0;
      #1;
      check("empty_pp_before", read_data, 32'h0);
      @(negedge clk);
      source_valid = 1'b0;
      #1;
      check("empty_pp_after", read_data, 32'h0777_7777);
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      read       = 1'b0;
      bus_read(1'b1, 32'h0000_0001, "empty_pp_status");

      for (int i = 0; i < 16; i++) begin
         push(28'h100 + 28'(i));
         check_const("fill");
      end
      bus_read(1'b1, 32'h0000_1002, "full_status");
      push(28'hDEADBEE);
      bus_read(1'b1, 32'h0000_1006, "ovf_status");
      bus_read(1'b1, 32'h0000_1002, "ovf_cleared");

      // Full FIFO with push and pop on the same edge: count unchanged, no overflow.
      @(negedge clk);
      source_valid = 1'b1;
      source_data  = 28'h0CAFE00;
      chipselect   = 1'b1;
      read         = 1'b1;
      address      = 1'b0;
      #1;
      check("full_pp_head", read_data, 32'h0000_0100);
      @(posedge clk);
      #1;
      source_valid = 1'b0;
      chipselect   = 1'b0;
      read         = 1'b0;
      bus_read(1'b1, 32'h0000_1002, "full_pp_status");

      @(negedge clk);
      chipselect = 1'b1;
      read       = 1'b1;
      address    = 1'b0;
      for (int i = 1; i < 16; i++) begin
         #1;
         check("drain", read_data, 32'h100 + 32'(i));
         @(negedge clk);
      end
      #1;
      check("drain_last", read_data, 32'h00CA_FE00);
      @(negedge clk);
      #1;
      check("drain_empty", read_data, 32'h0);
      chipselect = 1'b0;
      read       = 1'b0;
      bus_read(1'b1, 32'h0000_0001, "drain_status");

      // Overflow coinciding with a STATUS read: the set must win over the clear.
      for (int i = 0; i < 16; i++) begin
         push(28'h200 + 28'(i));
      end
      @(negedge clk);
      source_valid = 1'b1;
      source_data  = 28'h0FFFFFF;
      chipselect   = 1'b1;
      read         = 1'b1;
      address      = 1'b1;
      #1;
      check("setwin_during", read_data, 32'h0000_1002);
      @(posedge clk);
      #1;
      source_valid = 1'b0;
      chipselect   = 1'b0;
      read         = 1'b0;
      bus_read(1'b1, 32'h0000_1006, "setwin_after");
      bus_read(1'b0, 32'h0000_0200, "setwin_head");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
